// File: rtl/offchip_data_memory.sv
// -----------------------------------------------------------------------------
// offchip_data_memory
//
// Purpose:
//   Behavioural-but-synthesizable off-chip data memory that sits below the data
//   cache controller. Stores DEPTH lines of 256 bits and serves one whole line
//   per request with a fixed, parameterised latency and a one-cycle ack pulse.
//
// Parameters:
//   LATENCY   edges from request acceptance to the edge that raises ack_o (1..255)
//   DEPTH     number of 256-bit lines
//   IDX_BITS  line-index width, clog2(DEPTH)
//
// Ports:
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-low reset
//   addr_i    byte address; line index = addr_i[IDX_BITS+4:5]
//   data_i    write line data (word0 = [31:0])
//   enable_i  request valid, sampled only while idle
//   write_i   1 = write line, 0 = read line, sampled with enable_i
//   ack_o     one-cycle completion pulse (registered)
//   data_o    read line data, valid in the ack_o cycle of a read (registered)
//   err_o     one-cycle pulse with ack_o for an out-of-range request (registered)
//
// Configuration macro:
//   MEM_RANGE_CHECK_EN  when defined, addresses with any bit above the line
//                       index set are flagged with err_o, read as zero and
//                       drop their write. When undefined, the upper address
//                       bits are ignored (index wraps) and err_o stays 0.
// -----------------------------------------------------------------------------
module offchip_data_memory #(
  parameter int LATENCY  = 10,
  parameter int DEPTH    = 512,
  parameter int IDX_BITS = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic         ack_o,
  output logic [255:0] data_o,
  output logic         err_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  // Counter value at which the BUSY phase has lasted LATENCY edges.
  localparam logic [7:0] LAT_CNT = 8'(LATENCY);

  logic [1:0]          state_r;
  logic [7:0]          cnt_r;
  logic [IDX_BITS-1:0] idx_r;
  logic [255:0]        wdata_r;
  logic                write_r;
  logic                oor_r;
  logic                oor_s;
  logic                commit_s;
  logic [255:0]        mem_r [DEPTH];

  // Byte-offset bits never select anything; upper bits only matter with the
  // range check enabled. Folding them here keeps them visibly accounted for.
  logic unused_addr_bits_s;
  assign unused_addr_bits_s = ^{addr_i[31:IDX_BITS+5], addr_i[4:0]};

`ifdef MEM_RANGE_CHECK_EN
  // Any address bit above the line index makes the request out of range.
  function automatic logic out_of_range(input logic [31:0] addr);
    out_of_range = |(addr >> (IDX_BITS + 5));
  endfunction

  assign oor_s = out_of_range(addr_i);
`else
  assign oor_s = 1'b0;
`endif

  // A write lands in the array on the edge that leaves ACK, so a reset taken
  // in BUSY or ACK (which forces IDLE) discards the pending write.
  assign commit_s = (state_r == ACK) && write_r && !oor_r;

  // Line storage: written only at ACK exit, never reset.
  always_ff @(posedge clk_i) begin
    if (commit_s) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

  // Request FSM, captured request fields and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      idx_r   <= {IDX_BITS{1'b0}};
      wdata_r <= 256'd0;
      write_r <= 1'b0;
      oor_r   <= 1'b0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      data_o  <= 256'd0;
    end else begin
      // Pulses default low; they are raised only on the edge entering ACK.
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (enable_i) begin
            idx_r   <= addr_i[IDX_BITS+4:5];
            wdata_r <= data_i;
            write_r <= write_i;
            oor_r   <= oor_s;
            cnt_r   <= 8'd1;
            state_r <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          // cnt_r counts edges since acceptance; at LATENCY the ack edge is
          // reached, so ack_o rises in the cycle after acceptance+LATENCY.
          if (cnt_r >= LAT_CNT) begin
            state_r <= ACK;
            ack_o   <= 1'b1;
            err_o   <= oor_r;
            if (!write_r) begin
              data_o <= oor_r ? 256'd0 : mem_r[idx_r];
            end else begin
              data_o <= data_o;
            end
          end else begin
            cnt_r   <= cnt_r + 8'd1;
            state_r <= BUSY;
          end
        end
        ACK: begin
          // Mandatory return to IDLE; enable_i is not looked at here.
          cnt_r   <= 8'd0;
          state_r <= IDLE;
        end
        default: begin
          cnt_r   <= 8'd0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_offchip_data_memory.sv
// -----------------------------------------------------------------------------
// tb_offchip_data_memory
//
// Directed bench for offchip_data_memory. A LATENCY=10 instance carries the
// latency, write/read-back, back-to-back, mid-request reset and range tests;
// a LATENCY=1 instance covers the minimum-latency spacing.
// -----------------------------------------------------------------------------
module tb_offchip_data_memory;

  logic         clk = 1'b0;
  logic         rst = 1'b0;

  logic [31:0]  addr;
  logic [255:0] wdata;
  logic         enable;
  logic         write;
  logic         ack;
  logic [255:0] dout;
  logic         err;

  logic [31:0]  addr1;
  logic [255:0] wdata1;
  logic         enable1;
  logic         write1;
  logic         ack1;
  logic [255:0] dout1;
  logic         err1;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] PRE3 = {8{32'hA5A5_0003}};
  localparam logic [255:0] PAT  = 256'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321_1122_3344_5566_7788_99AA_BBCC_DDEE_FF00;
  localparam logic [255:0] OLD5 = {8{32'h5555_0005}};
  localparam logic [255:0] Z0   = {8{32'h0000_C0DE}};
  localparam logic [255:0] L511 = {8{32'h1FF1_1FF1}};
  localparam logic [255:0] Q2   = {8{32'h0BAD_F00D}};
  localparam logic [255:0] ONES = {256{1'b1}};

`ifdef MEM_RANGE_CHECK_EN
  localparam logic [255:0] EXP_OOR_RD   = 256'd0;
  localparam logic [255:0] EXP_OOR_ERR  = 256'd1;
  localparam logic [255:0] EXP_LINE0    = Z0;
`else
  localparam logic [255:0] EXP_OOR_RD   = Z0;
  localparam logic [255:0] EXP_OOR_ERR  = 256'd0;
  localparam logic [255:0] EXP_LINE0    = ONES;
`endif

  always #5 clk = ~clk;

  offchip_data_memory #(.LATENCY(10), .DEPTH(512), .IDX_BITS(9)) u_dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .addr_i   (addr),
    .data_i   (wdata),
    .enable_i (enable),
    .write_i  (write),
    .ack_o    (ack),
    .data_o   (dout),
    .err_o    (err)
  );

  offchip_data_memory #(.LATENCY(1), .DEPTH(512), .IDX_BITS(9)) u_lat1 (
    .clk_i    (clk),
    .rst_i    (rst),
    .addr_i   (addr1),
    .data_i   (wdata1),
    .enable_i (enable1),
    .write_i  (write1),
    .ack_o    (ack1),
    .data_o   (dout1),
    .err_o    (err1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on the LATENCY=10 instance: lat is the number of edges after
  // the acceptance edge until ack is seen (0 on timeout).
  task automatic xfer(input logic [31:0] a, input logic [255:0] d, input logic w,
                      output int lat, output logic [255:0] rd, output logic er);
    int k;
    addr = a; wdata = d; write = w; enable = 1'b1;
    step();
    enable = 1'b0; addr = 32'hFFFF_FFE0; wdata = ~d; write = ~w;
    lat = 0; rd = 256'd0; er = 1'b0; k = 0;
    while (lat == 0 && k < 40) begin
      step();
      k++;
      if (ack === 1'b1) begin
        lat = k; rd = dout; er = err;
      end
    end
    step();
    check("ack_single_cycle", {255'd0, ack}, 256'd0);
  endtask

  int           lat;
  logic [255:0] rd;
  logic         er;
  int           n_ack;
  int           ack_e [3];
  logic [255:0] ack_d [3];

  initial begin
    addr = 32'd0; wdata = 256'd0; enable = 1'b0; write = 1'b0;
    addr1 = 32'd0; wdata1 = 256'd0; enable1 = 1'b0; write1 = 1'b0;

    // Reset state
    #12;
    check("rst_ack", {255'd0, ack}, 256'd0);
    check("rst_err", {255'd0, err}, 256'd0);
    check("rst_data", dout, 256'd0);
    check("rst_ack1", {255'd0, ack1}, 256'd0);
    check("rst_data1", dout1, 256'd0);
    step();
    rst = 1'b1;
    step();

    // Preload line 3 through a write; data_o must stay at its reset value
    xfer(32'h0000_0060, PRE3, 1'b1, lat, rd, er);
    check("pre3_lat", 256'(lat), 256'd10);
    check("pre3_wr_data_hold", rd, 256'd0);
    check("pre3_err", {255'd0, er}, 256'd0);

    // T1 read latency
    xfer(32'h0000_0060, 256'd0, 1'b0, lat, rd, er);
    check("t1_lat", 256'(lat), 256'd10);
    check("t1_data", rd, PRE3);
    check("t1_err", {255'd0, er}, 256'd0);

    // T2 write then read back; data_o holds the previous read during the write ack
    xfer(32'h0000_0080, PAT, 1'b1, lat, rd, er);
    check("t2_wr_lat", 256'(lat), 256'd10);
    check("t2_wr_data_hold", rd, PRE3);
    xfer(32'h0000_0080, 256'd0, 1'b0, lat, rd, er);
    check("t2_rd_lat", 256'(lat), 256'd10);
    check("t2_rd_data", rd, PAT);

    // T3 enable held high for three reads; junk write to line 3 during BUSY/ACK
    n_ack = 0;
    for (int e = 0; e < 40; e++) begin
      if (e == 0 || e == 24) begin
        addr = 32'h0000_0060; write = 1'b0; wdata = 256'd0;
      end else if (e == 12) begin
        addr = 32'h0000_0080; write = 1'b0; wdata = 256'd0;
      end else begin
        addr = 32'h0000_0060; write = 1'b1; wdata = ONES;
      end
      enable = (e <= 24);
      step();
      if (ack === 1'b1) begin
        if (n_ack < 3) begin
          ack_e[n_ack] = e;
          ack_d[n_ack] = dout;
        end
        n_ack++;
      end
    end
    enable = 1'b0;
    check("t3_ack_count", 256'(n_ack), 256'd3);
    check("t3_ack0_edge", 256'(ack_e[0]), 256'd10);
    check("t3_ack1_edge", 256'(ack_e[1]), 256'd22);
    check("t3_ack2_edge", 256'(ack_e[2]), 256'd34);
    check("t3_ack0_data", ack_d[0], PRE3);
    check("t3_ack1_data", ack_d[1], PAT);
    check("t3_ack2_data", ack_d[2], PRE3);

    // T4 reset in the middle of a write to line 5
    xfer(32'h0000_00A0, OLD5, 1'b1, lat, rd, er);
    check("t4_pre_lat", 256'(lat), 256'd10);
    xfer(32'h0000_0060, 256'd0, 1'b0, lat, rd, er);
    check("t4_pre_rd", rd, PRE3);
    addr = 32'h0000_00A0; wdata = ONES; write = 1'b1; enable = 1'b1;
    step();
    enable = 1'b0; write = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    #1;
    check("t4_async_ack", {255'd0, ack}, 256'd0);
    check("t4_async_err", {255'd0, err}, 256'd0);
    check("t4_async_data", dout, 256'd0);
    step(); step();
    rst = 1'b1;
    n_ack = 0;
    for (int e = 0; e < 15; e++) begin
      step();
      if (ack === 1'b1) n_ack++;
    end
    check("t4_no_ack", 256'(n_ack), 256'd0);
    xfer(32'h0000_00A0, 256'd0, 1'b0, lat, rd, er);
    check("t4_rd_lat", 256'(lat), 256'd10);
    check("t4_old_data", rd, OLD5);

    // T5 range: 0x4000 is line 512
    xfer(32'h0000_0000, Z0, 1'b1, lat, rd, er);
    xfer(32'h0000_4000, 256'd0, 1'b0, lat, rd, er);
    check("t5_oor_lat", 256'(lat), 256'd10);
    check("t5_oor_rd", rd, EXP_OOR_RD);
    check("t5_oor_err", {255'd0, er}, EXP_OOR_ERR);
    xfer(32'h0000_4000, ONES, 1'b1, lat, rd, er);
    check("t5_oor_wr_err", {255'd0, er}, EXP_OOR_ERR);
    xfer(32'h0000_0000, 256'd0, 1'b0, lat, rd, er);
    check("t5_line0", rd, EXP_LINE0);
    check("t5_line0_err", {255'd0, er}, 256'd0);

    // Top line of the array
    xfer(32'h0000_3FE0, L511, 1'b1, lat, rd, er);
    xfer(32'h0000_3FE0, 256'd0, 1'b0, lat, rd, er);
    check("line511_data", rd, L511);
    check("line511_err", {255'd0, er}, 256'd0);

    // T6 LATENCY=1: write line 2 accepted at edge 0, read accepted at edge 3
    n_ack = 0;
    for (int e = 0; e < 8; e++) begin
      addr1 = 32'h0000_0040;
      write1 = (e == 0);
      wdata1 = (e == 0) ? Q2 : ONES;
      enable1 = (e <= 3);
      step();
      if (ack1 === 1'b1) begin
        if (n_ack < 3) begin
          ack_e[n_ack] = e;
          ack_d[n_ack] = dout1;
        end
        n_ack++;
      end
    end
    enable1 = 1'b0;
    check("t6_ack_count", 256'(n_ack), 256'd2);
    check("t6_ack0_edge", 256'(ack_e[0]), 256'd1);
    check("t6_ack1_edge", 256'(ack_e[1]), 256'd4);
    check("t6_wr_data_hold", ack_d[0], 256'd0);
    check("t6_rd_data", ack_d[1], Q2);
    check("t6_err", {255'd0, err1}, 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
